t_ff_bank_seq: RTL and testbench

Sequencer for a bank of `WIDTH` T flip-flops (`T_FLIPFLOP_ASY` instances or equivalent) that share one clock. The block computes the per-bit toggle-enable vector driving the bank's `t` inputs. It reads the bank's `q` outputs back, which lets the bank count up, count down for a programmed number of steps, or jump to a target value in one cycle. It sits between the control logic and the flip-flop bank, and is the only driver of the bank's `t` inputs.

---
 rtl/t_ff_bank_seq_if.sv | 27 ++
 rtl/t_ff_bank_seq.sv | 106 ++++++++++
 tb/tb_t_ff_bank_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/t_ff_bank_seq_if.sv
// Command/feedback bundle between the control logic and the T flip-flop bank sequencer.
// master = controller + bank side, slave = sequencer.
interface t_ff_bank_seq_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  target;
  logic              abort;
  logic [WIDTH-1:0]  q_in;
  logic [WIDTH-1:0]  t_out;
  logic              busy;
  logic              done;
  logic              tc;

  modport master (
    output start, mode, steps, target, abort, q_in,
    input  t_out, busy, done, tc
  );

  modport slave (
    input  start, mode, steps, target, abort, q_in,
    output t_out, busy, done, tc
  );
endinterface

// File: rtl/t_ff_bank_seq.sv
// Toggle-enable sequencer for a bank of T flip-flops: count up/down, load, abort.
// Define T_FF_BANK_SEQ_SAT_EN to make counts saturate instead of wrapping.
module t_ff_bank_seq #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input logic           clk,
  input logic           reset,
  t_ff_bank_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic              down;
  logic [WIDTH-1:0]  target_r;
  logic [STEP_W-1:0] step_cnt;
  logic              tc_r;

  logic [WIDTH-1:0]  match;
  logic [WIDTH-1:0]  tog;
  logic              run;
  logic              wrap;
  logic              sat_hit;
  logic              last_step;
  logic [WIDTH-1:0]  t_vec;

  // Bit i toggles when every lower bit is at its carry (up) or borrow (down) value;
  // the chain surviving all bits means this step wraps the bank.
  assign match = down ? ~bus.q_in : bus.q_in;

  always_comb begin
    tog = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = run;
      run    = run & match[i];
    end
  end

  assign wrap      = run;
  assign last_step = (step_cnt == STEP_W'(1));

`ifdef T_FF_BANK_SEQ_SAT_EN
  assign sat_hit = wrap;
`else
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    t_vec = '0;
    case (state)
      COUNT: if (!bus.abort && !sat_hit) t_vec = tog;
      LOAD:  t_vec = bus.q_in ^ target_r;
      default: t_vec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      down     <= 1'b0;
      target_r <= '0;
      step_cnt <= '0;
      tc_r     <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            down     <= bus.mode[0];
            target_r <= bus.target;
            step_cnt <= bus.steps;
            case (bus.mode)
              2'b00, 2'b01: state <= (bus.steps != '0) ? COUNT : DONE;
              2'b10:        state <= LOAD;
              default:      state <= DONE;
            endcase
          end
        end
        COUNT: begin
          if (bus.abort) begin
            state <= DONE;
          end else begin
            // tc also fires on a saturated step, where the bank itself holds still
            tc_r     <= wrap;
            step_cnt <= step_cnt - STEP_W'(1);
            if (last_step || sat_hit) state <= DONE;
          end
        end
        LOAD:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.t_out = t_vec;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.tc    = tc_r;

endmodule

// File: tb/tb_t_ff_bank_seq.sv
// Bench for t_ff_bank_seq: behavioural T-FF bank, directed vector table plus corner sequences.
// Expectations follow T_FF_BANK_SEQ_SAT_EN when the design is built with it.
module tb_t_ff_bank_seq;
  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;

  typedef struct {
    string             name;
    logic [1:0]        mode;
    logic [STEP_W-1:0] steps;
    logic [WIDTH-1:0]  target;
    logic [WIDTH-1:0]  init;
    logic [WIDTH-1:0]  exp_bank;
    int                exp_lat;
    int                exp_tc;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] preset_val;
  logic             preset_en;
  int               checks = 0;
  int               failures = 0;
  vec_t             vecs[10];

  t_ff_bank_seq_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  t_ff_bank_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The bank model: plain T flip-flops with a separate preset used only while idle
  assign bus.q_in = bank;
  always @(posedge clk) bank <= preset_en ? preset_val : (bank ^ bus.t_out);

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [STEP_W-1:0] s,
                               input logic [WIDTH-1:0] tg, input logic [WIDTH-1:0] init);
    preset_val = init;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
    bus.mode   = m;
    bus.steps  = s;
    bus.target = tg;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    int lat, tcs, busy_bad;
    applyStimulus(v.mode, v.steps, v.target, v.init);
    lat = 1; tcs = 0; busy_bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.tc) tcs++;
      if (!bus.busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (bus.tc) tcs++;
    if (!bus.busy) busy_bad++;
    checkOutput({v.name, "_latency"}, lat, v.exp_lat);
    checkOutput({v.name, "_bank"}, int'(bank), int'(v.exp_bank));
    checkOutput({v.name, "_tc_pulses"}, tcs, v.exp_tc);
    checkOutput({v.name, "_busy_gaps"}, busy_bad, 0);
    @(negedge clk);
    checkOutput({v.name, "_busy_after"}, int'(bus.busy), 0);
  endtask

  initial begin
    int done_seen, lat;
    reset      = 1'b1;
    preset_en  = 1'b1;
    preset_val = '0;
    bus.start  = 1'b0;
    bus.mode   = 2'b00;
    bus.steps  = '0;
    bus.target = '0;
    bus.abort  = 1'b0;

    vecs[0] = '{"up5",      2'b00, 8'd5,  4'h0, 4'h0, 4'h5, 6, 0};
    vecs[2] = '{"load_a5",  2'b10, 8'd0,  4'h5, 4'hA, 4'h5, 2, 0};
    vecs[3] = '{"noop",     2'b11, 8'd9,  4'h3, 4'h7, 4'h7, 1, 0};
    vecs[4] = '{"zero_step",2'b00, 8'd0,  4'h0, 4'h9, 4'h9, 1, 0};
    vecs[6] = '{"down5",    2'b01, 8'd5,  4'h0, 4'h6, 4'h1, 6, 0};
    vecs[8] = '{"load_00",  2'b10, 8'd3,  4'h0, 4'h0, 4'h0, 2, 0};
`ifdef T_FF_BANK_SEQ_SAT_EN
    vecs[1] = '{"down3",    2'b01, 8'd3,  4'h0, 4'h2, 4'h0, 4, 1};
    vecs[5] = '{"up_sat",   2'b00, 8'd4,  4'h0, 4'hE, 4'hF, 3, 1};
    vecs[7] = '{"up16",     2'b00, 8'd16, 4'h0, 4'h3, 4'hF, 14, 1};
    vecs[9] = '{"down_sat", 2'b01, 8'd5,  4'h0, 4'h1, 4'h0, 3, 1};
`else
    vecs[1] = '{"down3",    2'b01, 8'd3,  4'h0, 4'h2, 4'hF, 4, 1};
    vecs[5] = '{"up_wrap",  2'b00, 8'd4,  4'h0, 4'hE, 4'h2, 5, 1};
    vecs[7] = '{"up16",     2'b00, 8'd16, 4'h0, 4'h3, 4'h3, 17, 1};
    vecs[9] = '{"down_wrap",2'b01, 8'd5,  4'h0, 4'h1, 4'hC, 6, 1};
`endif

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_t_out", int'(bus.t_out), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_tc", int'(bus.tc), 0);
    reset     = 1'b0;
    preset_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) runVector(vecs[i]);

    // Count up edge by edge
    applyStimulus(2'b00, 8'd5, 4'h0, 4'h0);
    checkOutput("up_first_t_out", int'(bus.t_out), 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("up_edge%0d_bank", k), int'(bank), k);
    end
    checkOutput("up_edge_done", int'(bus.done), 1);
    @(negedge clk);

    // Load shows the full XOR for one cycle
    applyStimulus(2'b10, 8'd0, 4'h5, 4'hA);
    checkOutput("load_t_out", int'(bus.t_out), 15);
    @(negedge clk);
    checkOutput("load_bank", int'(bank), 5);
    checkOutput("load_done", int'(bus.done), 1);
    checkOutput("load_t_out_done", int'(bus.t_out), 0);
    @(negedge clk);

    // Abort after three steps
    applyStimulus(2'b00, 8'd10, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    #1;
    checkOutput("abort_t_out", int'(bus.t_out), 0);
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_done", int'(bus.done), 1);
    checkOutput("abort_bank", int'(bank), 3);
    @(negedge clk);
    checkOutput("abort_busy_after", int'(bus.busy), 0);

    // Reset in the middle of a count: the toggle in flight lands, then silence
    applyStimulus(2'b00, 8'd10, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_busy", int'(bus.busy), 0);
    checkOutput("midreset_t_out", int'(bus.t_out), 0);
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    checkOutput("midreset_no_done", done_seen, 0);
    checkOutput("midreset_bank", int'(bank), 3);

    // start while busy is ignored; back-to-back start right after DONE is taken
    applyStimulus(2'b00, 8'd3, 4'h0, 4'h0);
    bus.start  = 1'b1;
    bus.mode   = 2'b10;
    bus.target = 4'hF;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_start_latency", lat, 4);
    checkOutput("busy_start_bank", int'(bank), 3);
    @(negedge clk);
    checkOutput("b2b_idle_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    bus.mode  = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2b_done", int'(bus.done), 1);
    checkOutput("b2b_bank", int'(bank), 3);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
